// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and the nibble-to-glyph function shared by the scan driver.
// Latency: none, constants and pure functions only.
// Backpressure: none.
package seg7_pkg;

  // Active-high glyphs, bit order gfedcba (bit 6 = g, bit 0 = a).
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Hex nibble to active-high gfedcba glyph; lower-case b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      4'hF: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational decoder from one hex nibble to its active-high gfedcba glyph.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the input continuously.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex display driver with leading-zero blanking and tear-free frame updates.
// Latency: outputs registered, 1 cycle; a load reaches the pins on the frame_tick cycle after the next frame boundary.
// Backpressure: none; load is never refused, a newer load simply replaces an unconsumed one.
// Build option: define SEG7_BLINK_EN to add the blink counter and blink_mask gating.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  input  logic [DIGITS-1:0]   blink_mask,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_tick
);

  localparam int              IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int              PW       = $clog2(SCAN_DIV);
  localparam logic [IW-1:0]   IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);
  // All output polarity lives in this one bit, applied only at the output registers.
  localparam logic            POL      = (ACTIVE_LOW != 0);

  // Scan position.
  logic [PW-1:0]        pre_cnt, pre_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic                 pre_wrap;
  logic                 boundary;

  // Double-buffered display contents.
  logic [4*DIGITS-1:0]  pend_val;
  logic [DIGITS-1:0]    pend_dp;
  logic                 pend_flag;
  logic [4*DIGITS-1:0]  act_val, act_val_nxt;
  logic [DIGITS-1:0]    act_dp, act_dp_nxt;

  // Per-digit visibility and the selected digit's attributes.
  logic [DIGITS-1:0]    lz_mask;
  logic                 lz_run;
  logic [DIGITS-1:0]    blink_hide;
  logic [3:0]           sel_nib;
  logic                 sel_dp;
  logic                 sel_blank;
  logic [DIGITS-1:0]    sel_onehot;
  logic [6:0]           dec_seg;
  logic [6:0]           seg_hi;
  logic                 dp_hi;

  // Prescaler, digit index and frame boundary detection.
  always_comb begin
    pre_wrap = (pre_cnt == PRE_LAST);
    boundary = pre_wrap && (idx == IDX_LAST);
    pre_nxt  = pre_wrap ? '0 : pre_cnt + PW'(1);
    idx_nxt  = idx;
    if (pre_wrap) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else begin
      pre_cnt <= pre_nxt;
      idx     <= idx_nxt;
    end
  end

  // Active only changes on the boundary; a load in that very cycle bypasses pending.
  always_comb begin
    act_val_nxt = act_val;
    act_dp_nxt  = act_dp;
    if (boundary) begin
      if (load) begin
        act_val_nxt = value;
        act_dp_nxt  = dp_in;
      end else if (pend_flag) begin
        act_val_nxt = pend_val;
        act_dp_nxt  = pend_dp;
      end
    end
  end

  // Pending holds the newest mid-frame load until the boundary consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
    end else if (boundary) begin
      pend_flag <= 1'b0;
    end else if (load) begin
      pend_val  <= value;
      pend_dp   <= dp_in;
      pend_flag <= 1'b1;
    end
  end

  // Active display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val <= '0;
      act_dp  <= '0;
    end else begin
      act_val <= act_val_nxt;
      act_dp  <= act_dp_nxt;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int            BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_on, blink_on_nxt;

  // Frame counter; the phase flips after every BLINK_FRAMES completed frames.
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_on_nxt  = blink_on;
    if (boundary) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt_nxt = '0;
        blink_on_nxt  = ~blink_on;
      end else begin
        blink_cnt_nxt = blink_cnt + BW'(1);
      end
    end
  end

  // Blink state registers; the phase starts visible out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_on  <= blink_on_nxt;
    end
  end

  assign blink_hide = blink_on_nxt ? '0 : blink_mask;
`else
  // Without blink support the mask has no effect and nothing is ever hidden.
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_hide   = '0;
`endif

  // Leading-zero mask: walk down from the top digit while nibbles stay zero; digit 0 is never blanked.
  always_comb begin
    lz_mask = '0;
    lz_run  = blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (act_val_nxt[i*4 +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end

  // Pick the nibble, dp and visibility of the digit the output registers will show next.
  always_comb begin
    sel_nib    = 4'h0;
    sel_dp     = 1'b0;
    sel_blank  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        sel_nib       = act_val_nxt[i*4 +: 4];
        sel_dp        = act_dp_nxt[i];
        sel_blank     = lz_mask[i] | blink_hide[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nib (sel_nib),
    .seg (dec_seg)
  );

  assign seg_hi = sel_blank ? SEG_BLANK : dec_seg;
  assign dp_hi  = sel_dp & ~sel_blank;

  // Output registers: computed from next-state so pins track the registered index and active value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {7{POL}};
      dp         <= POL;
      dig_sel    <= {DIGITS{POL}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_hi ^ {7{POL}};
      dp         <= dp_hi ^ POL;
      dig_sel    <= sel_onehot ^ {DIGITS{POL}};
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle dwell, 2-frame blink, active-low pins.
// Expected digit drives are queued when a load is issued and popped when that digit is on the pins.
// Blink expectations follow SEG7_BLINK_EN, matching whichever build of the design is compiled.
module tb_seg7_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int ACTIVE_LOW   = 1;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        load       = 1'b0;
  logic [15:0] value      = '0;
  logic [3:0]  dp_in      = '0;
  logic        blank_lz   = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int tick_cnt;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dp         (dp),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  // Ticks seen before the current cycle; at a tick's negedge the frame number is tick_cnt+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= 0;
    else if (frame_tick) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  // Active-low pin levels expected while digit i of v is selected.
  function automatic exp_t exp_digit(input logic [15:0] v, input logic [3:0] d,
                                     input logic blz, input logic [3:0] hide, input int i);
    exp_t e;
    logic all_zero_above;
    logic blank;
    all_zero_above = 1'b1;
    for (int k = 3; k > i; k--) begin
      if (v[k*4 +: 4] != 4'h0) all_zero_above = 1'b0;
    end
    blank = (blz && (i != 0) && all_zero_above && (v[i*4 +: 4] == 4'h0)) || hide[i];
    e.sel = ~(4'b0001 << i);
    e.seg = blank ? 7'h7F : ~glyph(v[i*4 +: 4]);
    e.dp  = blank ? 1'b1 : ~d[i];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d,
                            input logic blz, input logic [3:0] hide);
    for (int i = 0; i < DIGITS; i++) sb.push_back(exp_digit(v, d, blz, hide, i));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_sel"}, 8'(dig_sel), 8'(e.sel));
      chk({tag, "_seg"}, 8'(seg), 8'(e.seg));
      chk({tag, "_dp"}, 8'(dp), 8'(e.dp));
    end
  endtask

  // Called on a frame_tick negedge: samples each digit at the start of its dwell.
  task automatic check_frame(input string tag);
    for (int i = 0; i < DIGITS; i++) begin
      if (i != 0) repeat (SCAN_DIV) @(negedge clk);
      pop_check($sformatf("%s_d%0d", tag, i));
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    load  = 1'b1;
    value = v;
    dp_in = d;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    drive_load(v, d);
    push_frame(v, d, blank_lz, 4'b0000);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 8'(frame_tick), 8'h01);
  endtask

  initial begin
    logic       saw1;
    logic       phase_on;
    logic [3:0] hide;
    int         n;

    // 1: reset levels, then digit 0 shows "0" one cycle after release.
    repeat (3) @(negedge clk);
    chk("rst_seg", 8'(seg), 8'h7F);
    chk("rst_dp", 8'(dp), 8'h01);
    chk("rst_sel", 8'(dig_sel), 8'h0F);
    chk("rst_tick", 8'(frame_tick), 8'h00);
    sb.push_back(exp_digit(16'h0000, 4'h0, 1'b0, 4'h0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    pop_check("rel");
    chk("rel_tick", 8'(frame_tick), 8'h00);

    // 2: mixed glyphs and a decimal point.
    do_load(16'h1A3F, 4'b0100);
    wait_tick("t2_tick");
    check_frame("t2");

    // 3: leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0000);
    wait_tick("t3a_tick");
    check_frame("t3a");
    do_load(16'h0000, 4'b0000);
    wait_tick("t3b_tick");
    check_frame("t3b");
    do_load(16'h0100, 4'b0000);
    wait_tick("t3c_tick");
    check_frame("t3c");
    blank_lz = 1'b0;

    // 4: last mid-frame load wins and nothing tears.
    do_load(16'h8888, 4'b0000);
    wait_tick("t4a_tick");
    check_frame("t4a");
    wait_tick("t4b_tick");
    @(negedge clk);
    saw1 = 1'b0;
    drive_load(16'h1111, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      if (seg === ~7'b0000110) saw1 = 1'b1;
    end
    do_load(16'h2222, 4'b0000);
    n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (seg === ~7'b0000110) saw1 = 1'b1;
    end
    chk("t4_no_stale_1", 8'(saw1), 8'h00);
    wait_tick("t4c_tick");
    check_frame("t4c");
    // Load placed exactly on the boundary cycle is on the pins with frame_tick.
    repeat (3) @(negedge clk);
    load  = 1'b1;
    value = 16'h3333;
    dp_in = 4'b1001;
    push_frame(16'h3333, 4'b1001, 1'b0, 4'b0000);
    @(negedge clk);
    load = 1'b0;
    chk("t4_bnd_tick", 8'(frame_tick), 8'h01);
    check_frame("t4d");

    // 5: blink on digit 0 over four consecutive frames.
    blink_mask = 4'b0001;
    drive_load(16'h4321, 4'b0000);
    for (int f = 0; f < 4; f++) begin
      wait_tick($sformatf("t5_tick%0d", f));
`ifdef SEG7_BLINK_EN
      phase_on = (((tick_cnt + 1) / BLINK_FRAMES) % 2) == 0;
`else
      phase_on = 1'b1;
`endif
      hide = phase_on ? 4'b0000 : blink_mask;
      $display("blink frame %0d visible=%0d", tick_cnt + 1, phase_on);
      push_frame(16'h4321, 4'b0000, 1'b0, hide);
      check_frame($sformatf("t5_f%0d", f));
    end
    blink_mask = 4'b0000;

    // 6: reset during digit 2 with a load pending.
    wait_tick("t6_tick");
    @(negedge clk);
    drive_load(16'hBEEF, 4'b1111);
    repeat (6) @(negedge clk);
    chk("t6_on_d2", 8'(dig_sel), 8'h0B);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_seg", 8'(seg), 8'h7F);
    chk("t6_rst_dp", 8'(dp), 8'h01);
    chk("t6_rst_sel", 8'(dig_sel), 8'h0F);
    chk("t6_rst_tick", 8'(frame_tick), 8'h00);
    repeat (2) @(negedge clk);
    sb.push_back(exp_digit(16'h0000, 4'h0, 1'b0, 4'h0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    pop_check("t6_rel");
    push_frame(16'h0000, 4'h0, 1'b0, 4'h0);
    wait_tick("t6b_tick");
    check_frame("t6b");

    chk("sb_drained", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised N-digit, time-multiplexed hex seven-segment display driver for the DE0 board-support layer. Takes a packed hex value plus decimal points, decodes each nibble to gfedcba segments, and scans the digits one at a time with a programmable dwell. It adds leading-zero blanking, per-digit blinking and tear-free frame-synchronous updates. It replaces one combinational decoder per digit wherever the display pins are shared or multiplexed.

## Interface
- DIGITS, 4: number of digits scanned (1..8).
- SCAN_DIV, 50000: clock cycles each digit stays selected (≥2).
- BLINK_FRAMES, 64: scan frames per blink half-period (≥1).
- ACTIVE_LOW, 1: 1 = segment, dp and dig_sel outputs are active-low; 0 = active-high.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures value and dp_in.
- value  in  4*DIGITS  hex nibbles; nibble 0 is the rightmost digit.
- dp_in  in  DIGITS  decimal-point enable per digit.
- blank_lz  in  1  level; blank leading zeros.
- blink_mask  in  DIGITS  level; digits that blink.
- seg  out  7  gfedcba segments of the selected digit.
- dp  out  1  decimal point of the selected digit.
- dig_sel  out  DIGITS  one-hot digit select.
- frame_tick  out  1  one-cycle pulse on each frame boundary.

## Operation
- Pending register: load writes value and dp_in into pending and sets a pending flag. A second load before the flag clears overwrites pending; the last load wins.
- Frame boundary: the cycle where the prescaler is at SCAN_DIV-1 and the digit index is at DIGITS-1.
  - If the flag is set, pending copies to active and the flag clears.
  - If load is asserted in that same cycle, its value goes straight to active and the flag clears.
  - Active never changes mid-frame, so the display never tears.
- Decode: 0-F map to the standard hex glyphs, bit order gfedcba. Active-high codes: 0=0111111, 1=0000110, 5=1101101, A=1110111, F=1110001.
- Leading-zero blanking: when blank_lz=1, digits from DIGITS-1 downward are blanked (segments off, dp off) while their nibble is 0. Scanning stops at the first non-zero nibble. Digit 0 is never blanked, so 0 displays "0".
- Blink: the blink phase toggles every BLINK_FRAMES frames and starts at "on". In the off phase, digits with blink_mask set are fully blanked.
- ACTIVE_LOW=1 inverts seg, dp and dig_sel at the output registers only.

## Timing
- Prescaler counts 0..SCAN_DIV-1, then wraps. At SCAN_DIV-1 the digit index advances, wrapping from DIGITS-1 to 0.
- All outputs are registered and reflect the current index with 1-cycle latency.
- Reset values:
  - Index 0, prescaler 0, active/pending 0, flag clear, blink phase on.
  - seg, dp and dig_sel at the "all off" level (1s when ACTIVE_LOW=1).
  - frame_tick 0.
- The first digit-0 drive appears 1 cycle after rst_n deasserts.
- frame_tick is high for exactly one cycle, the cycle after the boundary. It coincides with the first cycle the new active value is driven.
- Load-to-display latency: the next frame boundary plus 1 cycle. The maximum is DIGITS*SCAN_DIV+1 cycles.
- Reset mid-scan: all outputs go off asynchronously and any pending load is discarded.

## Configuration
- SEG7_BLINK_EN defined: blink counter, blink phase and blink_mask gating are present.
- SEG7_BLINK_EN undefined: blink_mask is ignored, the phase is permanently on and no blink counter is synthesised.

## Structure
- Package seg7_pkg contains:
  - The 16 glyph constants and SEG_BLANK.
  - The function hex_to_seg, returning active-high gfedcba.
- Sub-module seg7_hex_decode: combinational nibble-to-glyph decoder using seg7_pkg. It is instantiated once on the selected nibble.
- The top level holds the prescaler, digit index, pending/active registers, blink counter and output registers.

## Test plan
Common settings: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1.
1. Hold rst_n=0 -> seg=7'h7F, dp=1, dig_sel=4'hF, frame_tick=0. Release -> the next cycle dig_sel=4'b1110 and seg=~0111111 (digit 0 shows "0").
2. Load value=16'h1A3F, dp_in=4'b0100 -> after the frame boundary:
   - dig_sel=1110: seg=~1110001.
   - dig_sel=1011: seg=~1110111, dp=0.
3. blank_lz=1, load 16'h0005 -> digits 3..1 show seg=7'h7F, digit 0 shows ~1101101. Load 16'h0000 -> digit 0 shows "0". Load 16'h0100 -> only digit 3 is blanked.
4. Mid-frame load 16'h1111, then load 16'h2222 before the boundary -> "1" is never driven and all digits show "2". A load on the boundary cycle is driven on the frame_tick cycle.
5. SEG7_BLINK_EN defined, blink_mask=4'b0001 -> digit 0 is off for 2 frames, then on for 2 frames, repeating; the other digits are unaffected. Undefined -> digit 0 is always on.
6. Assert rst_n mid-dwell on digit 2 with a pending load -> outputs go off in the same cycle. After release, the index restarts at 0 and the display shows 0000.
